// File: rtl/keccak_ser_pkg.sv
// Shared types and helpers for the keccak digest serializer.
// bswap is used only when KECCAK_SER_BSWAP_EN is defined.
package keccak_ser_pkg;

  typedef enum logic {IDLE, SEND} ser_state_e;

  localparam int DIGEST_W_DEF   = 512;
  localparam int WORD_W_DEF     = 32;
  localparam int SHA3_512_WORDS = 16;
  localparam int SHA3_256_WORDS = 8;

  // Widest word the byte-swap helper handles.
  localparam int BSWAP_MAX_W = 256;

  // Reverse the low nbytes bytes of w; the bytes above them come back zero.
  function automatic logic [BSWAP_MAX_W-1:0] bswap(input logic [BSWAP_MAX_W-1:0] w,
                                                   input int nbytes);
    logic [BSWAP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BSWAP_MAX_W/8; i++) begin
      if (i < nbytes) r[8*i +: 8] = w[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_digest_serializer.sv
// Captures one keccak digest per digest_ready rising edge and streams it out as
// WORD_W words, MS word first. Define KECCAK_SER_BSWAP_EN to byte-reverse each word.
module keccak_digest_serializer
  import keccak_ser_pkg::*;
#(
  parameter int DIGEST_W  = DIGEST_W_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int OUT_WORDS = SHA3_512_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                digest_ready,
  output logic [WORD_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                busy,
  output logic                overrun
);

  localparam int IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_WORDS - 1);

  ser_state_e          state_q, state_d;
  logic [DIGEST_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rdy_q;
  logic                overrun_q, overrun_d;

  logic rise, xfer, sending, at_last;
  logic [WORD_W-1:0] word_sel;

  assign rise    = digest_ready & ~rdy_q;
  assign sending = (state_q == SEND);
  assign xfer    = sending & dout_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          shreg_d = digest;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A second hash while busy is flagged but never captured, even on the final transfer.
        if (rise) overrun_d = 1'b1;
        if (xfer) begin
          shreg_d = shreg_q << WORD_W;
          idx_d   = idx_q + IDX_W'(1);
          if (at_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      rdy_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      rdy_q     <= digest_ready;
      overrun_q <= overrun_d;
    end
  end

  // Zero dout outside SEND so a partly shifted register never leaks onto the bus.
  assign word_sel = sending ? shreg_q[DIGEST_W-1 -: WORD_W] : '0;

`ifdef KECCAK_SER_BSWAP_EN
  logic [BSWAP_MAX_W-1:0] swapped;
  assign swapped = bswap(BSWAP_MAX_W'(word_sel), WORD_W/8);
  assign dout    = swapped[WORD_W-1:0];
`else
  assign dout    = word_sel;
`endif

  assign dout_valid = sending;
  assign dout_last  = sending & at_last;
  assign busy       = sending;
  assign overrun    = overrun_q;

endmodule
